out_uart: RTL and testbench

OUT_UART -- requirements
Module: out_uart

---
 rtl/out_uart_pkg.sv | 33 +++
 rtl/out_uart_fifo.sv | 53 +++++
 rtl/out_uart.sv | 147 ++++++++++++++
 tb/tb_out_uart.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_uart_pkg.sv
// rtl/out_uart_pkg.sv - shared types, constants and helpers for out_uart
//
// Purpose : FSM state type, CR/LF character constants and the nibble-to-ASCII
//           mapping used by the out_uart serialiser.
// Macro   : OUT_UART_CRLF_EN adds the frame-phase type used to append CR/LF.
package out_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

`ifdef OUT_UART_CRLF_EN
  // Which character of the hex/CR/LF triple the current frame carries.
  typedef enum logic [1:0] {
    PH_CHAR,
    PH_CR,
    PH_LF
  } phase_e;
`endif

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/out_uart_fifo.sv
// rtl/out_uart_fifo.sv - parameterised nibble FIFO for out_uart
//
// Purpose : first-in first-out queue of 4-bit values, DEPTH entries.
// Ports   : clk, rst_n    - clock, asynchronous active-low reset
//           push_i, din_i - write request and data
//           pop_i         - read request (head advances)
//           full_o        - no free entry
//           empty_o       - no stored entry
//           dout_o        - current head entry
module out_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [3:0] din_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [3:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]  mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        pop_ok;
  logic        push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so a push into a full queue is kept.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/out_uart.sv
// rtl/out_uart.sv - CPU output-port change logger over a UART line
//
// Purpose : every change of din is queued and sent as one ASCII hex character,
//           8N1, LSB first, BAUD_DIV clocks per bit.
// Ports   : clk      - system clock
//           rst_n    - asynchronous active-low reset
//           din      - CPU output-port value
//           tx       - serial line, idle high
//           busy     - queue non-empty or frame in progress
//           overflow - sticky, a change was dropped on a full queue
// Macro   : OUT_UART_CRLF_EN - follow every character with CR and LF frames.
module out_uart
  import out_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [3:0]    din_q;
  logic          change;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    fifo_dout;
  logic          pop;
  logic          overflow_q;
  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          baud_end;
`ifdef OUT_UART_CRLF_EN
  phase_e        phase_q;
`endif

  assign change   = (din != din_q);
  assign pop      = (state_q == ST_IDLE) && !fifo_empty;
  assign baud_end = (baud_q == BAUD_LAST);
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign tx       = tx_q;
  assign overflow = overflow_q;

  out_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (change),
    .din_i   (din),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q      <= 4'h0;
      overflow_q <= 1'b0;
    end else begin
      din_q <= din;
      if (change && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= 8'hFF;
      tx_q    <= 1'b1;
`ifdef OUT_UART_CRLF_EN
      phase_q <= PH_CHAR;
`endif
    end else begin
      // The line follows the state one clock later, so the start bit appears
      // two edges after the edge that queued the change.
      case (state_q)
        ST_START: tx_q <= 1'b0;
        ST_DATA:  tx_q <= shift_q[0];
        default:  tx_q <= 1'b1;
      endcase

      // Reload at every bit boundary so bit periods never accumulate error.
      if (state_q == ST_IDLE || baud_end) baud_q <= '0;
      else                                baud_q <= baud_q + CW'(1);

      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_q <= nibble_to_ascii(fifo_dout);
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_end) begin
            bit_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            shift_q <= {1'b1, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
`ifdef OUT_UART_CRLF_EN
            // CR and LF follow directly, without passing through IDLE.
            case (phase_q)
              PH_CHAR: begin
                shift_q <= ASCII_CR;
                phase_q <= PH_CR;
                state_q <= ST_START;
              end
              PH_CR: begin
                shift_q <= ASCII_LF;
                phase_q <= PH_LF;
                state_q <= ST_START;
              end
              default: begin
                phase_q <= PH_CHAR;
                state_q <= ST_IDLE;
              end
            endcase
`else
            state_q <= ST_IDLE;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_uart.sv
// tb/tb_out_uart.sv - self-checking bench for out_uart
module tb_out_uart;

  localparam int B = 4;
  localparam int D = 4;
`ifdef OUT_UART_CRLF_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 1;
`endif
  localparam int FR = 10 * B * NCH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = 4'h0;
  logic       tx;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0] din;
    logic [7:0] ch;
  } vec_t;
  vec_t vecs[8];

  out_uart #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_char(input logic [7:0] ch);
    exp_q.push_back(ch);
`ifdef OUT_UART_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || rx_act) && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle", 32'(busy | rx_act), 0);
    repeat (3) tick();
  endtask

  // Expected line level c cycles into the frame(s) started by din=5.
  function automatic logic exp_bit_35(input int c);
    logic [7:0] ch;
    int f;
    int bi;
    f  = c / (10 * B);
    bi = (c % (10 * B)) / B;
    ch = (f == 0) ? 8'h35 : (f == 1) ? 8'h0D : 8'h0A;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return ch[bi-1];
  endfunction

  // UART receiver: samples at the falling clock edge, mid-bit.
  logic       rx_act = 1'b0;
  int         rx_k = 0;
  logic [7:0] rx_sr = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act = 1'b1;
        rx_k   = 0;
      end
    end else begin
      rx_k++;
      if (rx_k > B && rx_k < 9 * B && (rx_k % B) == 1) rx_sr = {tx, rx_sr[7:1]};
      if (rx_k == 9 * B + 1) begin
        check("rx_stop", 32'(tx), 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_sr);
        end else begin
          check("rx_char", 32'(rx_sr), 32'(exp_q.pop_front()));
        end
        rx_act = 1'b0;
      end
    end
  end

  initial begin
    logic bad;
    vecs[0] = '{4'h0, 8'h30};
    vecs[1] = '{4'h9, 8'h39};
    vecs[2] = '{4'hC, 8'h43};
    vecs[3] = '{4'h3, 8'h33};
    vecs[4] = '{4'hE, 8'h45};
    vecs[5] = '{4'h1, 8'h31};
    vecs[6] = '{4'hB, 8'h42};
    vecs[7] = '{4'h7, 8'h37};

    // Reset state
    tick();
    tick();
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // 0 -> 5: latency and bit-exact frame(s)
    din = 4'h5;
    expect_char(8'h35);
    tick();
    tick();
    check("lat5_pre", 32'(tx), 1);
    for (int c = 0; c < FR; c++) begin
      tick();
      check("frame5_bit", 32'(tx), 32'(exp_bit_35(c)));
      if (c < FR - 1) check("frame5_busy", 32'(busy), 1);
    end
    tick();
    check("frame5_end_tx", 32'(tx), 1);
    check("frame5_end_busy", 32'(busy), 0);
    wait_idle(50);

    // 5 -> A -> F back-to-back: one idle cycle between frames
    din = 4'hA;
    expect_char(8'h41);
    tick();
    din = 4'hF;
    expect_char(8'h46);
    tick();
    tick();
    check("b2b_start1", 32'(tx), 0);
    repeat (FR) tick();
    check("b2b_gap", 32'(tx), 1);
    tick();
    check("b2b_start2", 32'(tx), 0);
    wait_idle(300);

    // Table of single changes
    for (int i = 0; i < 8; i++) begin
      din = vecs[i].din;
      expect_char(vecs[i].ch);
      tick();
      check("vec_busy", 32'(busy), 1);
      tick();
      check("vec_lat_pre", 32'(tx), 1);
      tick();
      check("vec_lat", 32'(tx), 0);
      wait_idle(300);
    end

    // Six consecutive changes against a four-deep queue
    rst_n = 1'b0;
    din = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int v = 1; v <= 6; v++) begin
      din = 4'(v);
      if (v <= 5) expect_char(8'h30 + 8'(v));
      tick();
    end
    check("ovf_set", 32'(overflow), 1);
    wait_idle(1500);
    check("ovf_sticky", 32'(overflow), 1);

    // Reset during data bit 3
    din = 4'h7;
    tick();
    tick();
    tick();
    check("rst_mid_start", 32'(tx), 0);
    repeat (17) tick();
    check("rst_mid_bit3", 32'(tx), 0);
    rst_n = 1'b0;
    din = 4'h0;
    #1;
    check("rst_mid_tx", 32'(tx), 1);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_ovf", 32'(overflow), 0);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("rst_mid_no_residual", 32'(bad), 0);

    // Non-zero din at reset release counts as a change
    rst_n = 1'b0;
    din = 4'h8;
    tick();
    rst_n = 1'b1;
    expect_char(8'h38);
    tick();
    check("rel_change_busy", 32'(busy), 1);
    wait_idle(300);

    // Push onto a full queue on the same edge as a pop
    rst_n = 1'b0;
    din = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int v = 1; v <= 5; v++) begin
      din = 4'(v);
      expect_char(8'h30 + 8'(v));
      tick();
    end
    repeat (FR - 3) tick();
    din = 4'h6;
    expect_char(8'h36);
    tick();
    check("full_pushpop_ovf", 32'(overflow), 0);
    wait_idle(1500);
    check("full_pushpop_ovf_end", 32'(overflow), 0);

    // din constant: nothing happens
    bad = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("steady_quiet", 32'(bad), 0);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
